// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package mc_pkg;

    // FSM states; FETCH is zero, the rest follow the instruction flow order.
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    // Opcodes understood by the decoder.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // What the ALU decoder should produce: fixed add, fixed subtract, or funct-driven.
    typedef enum logic [1:0] {
        ADD   = 2'd0,
        SUB   = 2'd1,
        FUNCT = 2'd2
    } aluop_t;

    // ALU operation codes (4-bit native encoding).
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // R-type function fields.
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // True when the opcode has a defined execution path; bne only when enabled.
    function automatic logic op_supported(input logic [5:0] opc, input logic bne_en);
        logic ok;
        ok = 1'b0;
        case (opc)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            OP_BNE:  ok = bne_en;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decoder: maps the FSM's ALU request and funct to an ALU code.
module mc_aludec
    import mc_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  aluop_t               aluop,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alucontrol
);

    logic [3:0] ctrl;

    // Unknown funct codes fall back to add; writeback is never suppressed here.
    always_comb begin
        ctrl = ALU_ADD;
        case (aluop)
            ADD: ctrl = ALU_ADD;
            SUB: ctrl = ALU_SUB;
            FUNCT: begin
                case (funct)
                    FN_ADD:  ctrl = ALU_ADD;
                    FN_SUB:  ctrl = ALU_SUB;
                    FN_AND:  ctrl = ALU_AND;
                    FN_OR:   ctrl = ALU_OR;
                    FN_SLT:  ctrl = ALU_SLT;
                    default: ctrl = ALU_ADD;
                endcase
            end
            default: ctrl = ALU_ADD;
        endcase
    end

    assign alucontrol = ALUCTRL_W'(ctrl);

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle MIPS datapath (shared ALU, unified memory).
//
// Memory handshake: in FETCH, MEMRD and MEMWR the FSM presents a request (address
// select, and memwrite for stores) and holds every output steady until a cycle in
// which mem_ready=1; that cycle completes the access and the FSM advances on the
// following edge. mem_ready is ignored in every other state.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter bit BNE_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pcen,
    output logic                 iord,
    output logic                 irwrite,
    output logic                 memwrite,
    output logic                 memtoreg,
    output logic                 regdst,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal,
    output logic [3:0]           state
);

    state_t                state_q;
    state_t                state_d;
    aluop_t                aluop;
    logic                  alu_en;
    logic [ALUCTRL_W-1:0]  dec_ctrl;
    logic                  irw_s;
    logic                  pcw_s;
    logic                  mw_s;
    logic                  rw_s;
    logic                  ill_s;
    logic                  branch;
    logic                  is_bne;

    assign is_bne = BNE_EN && (op == OP_BNE);

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic: only FETCH, MEMRD and MEMWR may hold for more than one cycle.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_BNE:       state_d = BNE_EN ? BRANCH : FETCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Moore output decode; every output defaults to 0 outside the states that use it.
    always_comb begin
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        irw_s    = 1'b0;
        pcw_s    = 1'b0;
        mw_s     = 1'b0;
        rw_s     = 1'b0;
        ill_s    = 1'b0;
        branch   = 1'b0;
        alu_en   = 1'b0;
        aluop    = ADD;
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                alu_en  = 1'b1;
                irw_s   = mem_ready;
                pcw_s   = mem_ready;
            end
            DECODE: begin
                alusrcb = 2'b11;
                alu_en  = 1'b1;
                ill_s   = !op_supported(op, BNE_EN);
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                alu_en  = 1'b1;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                rw_s     = 1'b1;
            end
            MEMWR: begin
                iord = 1'b1;
                mw_s = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                alu_en  = 1'b1;
                aluop   = FUNCT;
            end
            ALUWB: begin
                regdst = 1'b1;
                rw_s   = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                alu_en  = 1'b1;
                aluop   = SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                alu_en  = 1'b1;
            end
            ADDIWB:  rw_s = 1'b1;
            JUMP: begin
                pcsrc = 2'b10;
                pcw_s = 1'b1;
            end
            default: ;
        endcase
    end

    mc_aludec #(.ALUCTRL_W(ALUCTRL_W)) u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (dec_ctrl)
    );

    assign alucontrol = alu_en ? dec_ctrl : '0;

    // Write strobes are squashed while reset is high so an aborted instruction never commits.
    assign pcen     = !reset && (pcw_s || (branch && (zero ^ is_bne)));
    assign irwrite  = !reset && irw_s;
    assign memwrite = !reset && mw_s;
    assign regwrite = !reset && rw_s;
    assign illegal  = !reset && ill_s;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: reset, table vectors, random instructions.
module tb_multicycle_controller;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXECUTE = 4'd6, S_ALUWB = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11;

    localparam logic [5:0] O_RT = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011;
    localparam logic [5:0] O_BEQ = 6'b000100, O_BNE = 6'b000101, O_ADDI = 6'b001000;
    localparam logic [5:0] O_J = 6'b000010, O_BAD = 6'b111111;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, irw, mw, m2r, rdst, rw, asa;
        logic [1:0] asb, pcs;
        logic [3:0] alu;
        logic       ill;
    } out_t;

    typedef struct packed {
        logic mr;
        out_t o;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         sf;
        int         sm;
        int         exp_len;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;

    logic       pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol, state;

    logic       nb_pcen, nb_iord, nb_irwrite, nb_memwrite, nb_memtoreg, nb_regdst;
    logic       nb_regwrite, nb_alusrca, nb_illegal;
    logic [1:0] nb_alusrcb, nb_pcsrc;
    logic [3:0] nb_alucontrol, nb_state;

    int   n_cmp = 0;
    int   n_bad = 0;
    cyc_t sched[$];

    always #5 clk = ~clk;

    multicycle_controller #(.ALUCTRL_W(4), .BNE_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .memtoreg(memtoreg),
        .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    multicycle_controller #(.ALUCTRL_W(4), .BNE_EN(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(nb_pcen), .iord(nb_iord), .irwrite(nb_irwrite), .memwrite(nb_memwrite),
        .memtoreg(nb_memtoreg), .regdst(nb_regdst), .regwrite(nb_regwrite),
        .alusrca(nb_alusrca), .alusrcb(nb_alusrcb), .pcsrc(nb_pcsrc),
        .alucontrol(nb_alucontrol), .illegal(nb_illegal), .state(nb_state)
    );

    // Reference: ALU code an R-type funct should select.
    function automatic logic [3:0] alu_model(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    // Reference: fixed output table of each step of an instruction.
    function automatic out_t step_out(input logic [3:0] s);
        out_t o;
        o = '0;
        o.st = s;
        case (s)
            S_FETCH:   begin o.asb = 2'b01; o.alu = 4'b0010; end
            S_DECODE:  begin o.asb = 2'b11; o.alu = 4'b0010; end
            S_MEMADR:  begin o.asa = 1'b1; o.asb = 2'b10; o.alu = 4'b0010; end
            S_MEMRD:   o.iord = 1'b1;
            S_MEMWB:   begin o.m2r = 1'b1; o.rw = 1'b1; end
            S_MEMWR:   begin o.iord = 1'b1; o.mw = 1'b1; end
            S_EXECUTE: o.asa = 1'b1;
            S_ALUWB:   begin o.rdst = 1'b1; o.rw = 1'b1; end
            S_BRANCH:  begin o.asa = 1'b1; o.alu = 4'b0110; o.pcs = 2'b01; end
            S_ADDIEX:  begin o.asa = 1'b1; o.asb = 2'b10; o.alu = 4'b0010; end
            S_ADDIWB:  o.rw = 1'b1;
            S_JUMP:    begin o.pcs = 2'b10; o.pcen = 1'b1; end
            default:   ;
        endcase
        return o;
    endfunction

    function automatic logic legal(input logic [5:0] o);
        return (o == O_RT) || (o == O_LW) || (o == O_SW) || (o == O_BEQ) ||
               (o == O_BNE) || (o == O_ADDI) || (o == O_J);
    endfunction

    // Reference: instruction length from the cycle-count rules.
    function automatic int len_model(input logic [5:0] o, input int sf, input int sm);
        int base;
        case (o)
            O_LW:                      base = 5 + sm;
            O_SW:                      base = 4 + sm;
            O_RT, O_ADDI:              base = 4;
            O_BEQ, O_BNE, O_J:         base = 3;
            default:                   base = 2;
        endcase
        return base + sf;
    endfunction

    function automatic out_t observe();
        out_t g;
        g.st = state; g.pcen = pcen; g.iord = iord; g.irw = irwrite; g.mw = memwrite;
        g.m2r = memtoreg; g.rdst = regdst; g.rw = regwrite; g.asa = alusrca;
        g.asb = alusrcb; g.pcs = pcsrc; g.alu = alucontrol; g.ill = illegal;
        return g;
    endfunction

    task automatic check_out(input string nm, input out_t exp);
        out_t got;
        got = observe();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (state %0d vs %0d)", nm, got, exp, got.st, exp.st);
        end
    endtask

    task automatic check_val(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic push(input logic mr, input out_t o);
        cyc_t c;
        c.mr = mr;
        c.o  = o;
        sched.push_back(c);
    endtask

    // Expected cycle-by-cycle trace of one instruction, including memory stalls.
    task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int sf, input int sm);
        out_t e;
        sched.delete();
        for (int k = 0; k < sf; k++) push(1'b0, step_out(S_FETCH));
        e = step_out(S_FETCH); e.irw = 1'b1; e.pcen = 1'b1;
        push(1'b1, e);
        e = step_out(S_DECODE); e.ill = !legal(o);
        push(1'($urandom_range(0, 1)), e);
        if (o == O_LW || o == O_SW) begin
            push(1'($urandom_range(0, 1)), step_out(S_MEMADR));
            if (o == O_LW) begin
                for (int k = 0; k < sm; k++) push(1'b0, step_out(S_MEMRD));
                push(1'b1, step_out(S_MEMRD));
                push(1'($urandom_range(0, 1)), step_out(S_MEMWB));
            end else begin
                for (int k = 0; k < sm; k++) push(1'b0, step_out(S_MEMWR));
                push(1'b1, step_out(S_MEMWR));
            end
        end else if (o == O_RT) begin
            e = step_out(S_EXECUTE); e.alu = alu_model(f);
            push(1'($urandom_range(0, 1)), e);
            push(1'($urandom_range(0, 1)), step_out(S_ALUWB));
        end else if (o == O_BEQ || o == O_BNE) begin
            e = step_out(S_BRANCH); e.pcen = z ^ (o == O_BNE);
            push(1'($urandom_range(0, 1)), e);
        end else if (o == O_ADDI) begin
            push(1'($urandom_range(0, 1)), step_out(S_ADDIEX));
            push(1'($urandom_range(0, 1)), step_out(S_ADDIWB));
        end else if (o == O_J) begin
            push(1'($urandom_range(0, 1)), step_out(S_JUMP));
        end
    endtask

    // Apply a trace, check every cycle, and measure how long the DUT took to return to FETCH.
    task automatic run(input string nm, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input int exp_len);
        int meas;
        bit left;
        meas = -1;
        left = 1'b0;
        for (int i = 0; i < sched.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin op = o; funct = f; zero = z; end
            mem_ready = sched[i].mr;
            #1;
            check_out($sformatf("%s_cyc%0d", nm, i), sched[i].o);
            if (state != S_FETCH) left = 1'b1;
            else if (left && meas < 0) meas = i;
        end
        @(posedge clk);
        #1;
        if (state == S_FETCH && left && meas < 0) meas = sched.size();
        check_val($sformatf("%s_len", nm), 8'(meas), 8'(exp_len));
    endtask

    vec_t tv[$];
    logic [5:0] fsel[6];

    initial begin
        reset = 1'b1; op = O_BNE; funct = '0; zero = 1'b0; mem_ready = 1'b1;

        // Reset held two cycles: all strobes squashed.
        repeat (2) begin
            @(negedge clk); #1;
            check_val("rst_strobes", 8'({pcen, irwrite, memwrite, regwrite, illegal}), 8'd0);
            check_val("rst_strobes_nb", 8'({nb_pcen, nb_irwrite, nb_memwrite, nb_regwrite, nb_illegal}), 8'd0);
        end
        @(negedge clk); reset = 1'b0; #1;
        begin
            out_t e;
            e = step_out(S_FETCH); e.irw = 1'b1; e.pcen = 1'b1;
            check_out("post_rst_fetch", e);
        end
        // bne with BNE_EN=0 is illegal; with BNE_EN=1 it branches (zero=0 -> taken).
        @(negedge clk); #1;
        check_val("nb_decode_illegal", 8'({nb_state, nb_illegal}), 8'({S_DECODE, 1'b1}));
        check_val("bne_decode_legal", 8'({state, illegal}), 8'({S_DECODE, 1'b0}));
        @(negedge clk); #1;
        check_val("nb_back_fetch", 8'({nb_state, nb_illegal}), 8'({S_FETCH, 1'b0}));
        check_val("bne_branch_pcen", 8'({state, pcen}), 8'({S_BRANCH, 1'b1}));
        @(posedge clk); #1;

        // Directed table: {op, funct, zero, fetch stalls, mem stalls, expected length}.
        tv.push_back('{O_LW,   6'b000000, 1'b0, 0, 2, 7});
        tv.push_back('{O_SW,   6'b000000, 1'b0, 0, 3, 7});
        tv.push_back('{O_RT,   6'b100000, 1'b0, 0, 0, 4});
        tv.push_back('{O_RT,   6'b100010, 1'b0, 0, 0, 4});
        tv.push_back('{O_RT,   6'b100100, 1'b0, 0, 0, 4});
        tv.push_back('{O_RT,   6'b100101, 1'b0, 0, 0, 4});
        tv.push_back('{O_RT,   6'b101010, 1'b0, 0, 0, 4});
        tv.push_back('{O_RT,   6'b000000, 1'b0, 0, 0, 4});
        tv.push_back('{O_BEQ,  6'b000000, 1'b1, 0, 0, 3});
        tv.push_back('{O_BEQ,  6'b000000, 1'b0, 0, 0, 3});
        tv.push_back('{O_BNE,  6'b000000, 1'b1, 0, 0, 3});
        tv.push_back('{O_BNE,  6'b000000, 1'b0, 0, 0, 3});
        tv.push_back('{O_J,    6'b000000, 1'b0, 0, 0, 3});
        tv.push_back('{O_ADDI, 6'b000000, 1'b0, 0, 0, 4});
        tv.push_back('{O_BAD,  6'b000000, 1'b0, 0, 0, 2});
        tv.push_back('{O_LW,   6'b000000, 1'b0, 2, 0, 7});
        for (int i = 0; i < tv.size(); i++) begin
            build(tv[i].op, tv[i].funct, tv[i].zero, tv[i].sf, tv[i].sm);
            run($sformatf("vec%0d", i), tv[i].op, tv[i].funct, tv[i].zero, tv[i].exp_len);
        end

        // Random instruction stream with random stalls.
        fsel = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011011};
        for (int i = 0; i < 60; i++) begin
            logic [5:0] ro, rf;
            logic rz;
            int rsf, rsm;
            case ($urandom_range(0, 7))
                0: ro = O_RT;   1: ro = O_LW;   2: ro = O_SW;   3: ro = O_BEQ;
                4: ro = O_BNE;  5: ro = O_ADDI; 6: ro = O_J;
                default: begin
                    ro = 6'($urandom_range(0, 63));
                    while (legal(ro)) ro = 6'($urandom_range(0, 63));
                end
            endcase
            rf  = fsel[$urandom_range(0, 5)];
            rz  = 1'($urandom_range(0, 1));
            rsf = $urandom_range(0, 3);
            rsm = $urandom_range(0, 3);
            build(ro, rf, rz, rsf, rsm);
            run($sformatf("rnd%0d", i), ro, rf, rz, len_model(ro, rsf, rsm));
        end

        // Store interrupted by reset while waiting in MEMWR.
        @(negedge clk); op = O_SW; mem_ready = 1'b1; #1;
        @(negedge clk); mem_ready = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check_out("sw_memwr_wait", step_out(S_MEMWR));
        @(negedge clk); reset = 1'b1; #1;
        check_val("rst_memwr_strobes", 8'({memwrite, regwrite, pcen, irwrite}), 8'd0);
        @(negedge clk); reset = 1'b0; mem_ready = 1'b1; #1;
        begin
            out_t e;
            e = step_out(S_FETCH); e.irw = 1'b1; e.pcen = 1'b1;
            check_out("rst_memwr_fetch", e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
